lcd_scan_gen: RTL and testbench

Pixel-clock and raster scan generator for the 480x272 RGB LCD. It divides `i_clk` into the panel pixel clock and produces the `o_x`/`o_y` coordinate stream that the layer renderers consume. It captures the 24-bit colour the renderers return one pixel period later and drives it to the panel pins with aligned DE/HSYNC/VSYNC. It is the scan master for the layer pipeline and the only block that talks to the panel.

---
 rtl/lcd_timing_pkg.sv | 30 +++
 rtl/lcd_scan_gen_if.sv | 28 ++
 rtl/lcd_axis_counter.sv | 70 +++++++
 rtl/lcd_scan_gen.sv | 125 ++++++++++++
 tb/tb_lcd_scan_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Panel timing defaults, phase encoding and shared widths for the LCD
// raster scan generator.
package lcd_timing_pkg;

    localparam int DEF_CLK_DIV  = 8;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COLOR_W = 24;
    localparam int CNT_W   = 10;
    localparam int POS_W   = 9;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

endpackage

// File: rtl/lcd_scan_gen_if.sv
// Scan-side bundle: coordinate stream out to the renderers, colour back in,
// and the panel pins.
interface lcd_scan_gen_if;
    import lcd_timing_pkg::*;

    // o_x/o_y change on the o_lcd_clk rising edge; i_color must be stable
    // by the last i_clk of that pixel period, panel pins follow one period later.
    logic [COLOR_W-1:0] i_color;
    logic               o_lcd_clk;
    logic [POS_W-1:0]   o_x;
    logic [POS_W-1:0]   o_y;
    logic [COLOR_W-1:0] o_rgb;
    logic               o_de;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_frame_start;

    modport master (
        input  i_color,
        output o_lcd_clk, o_x, o_y, o_rgb, o_de, o_hsync, o_vsync, o_frame_start
    );

    modport slave (
        output i_color,
        input  o_lcd_clk, o_x, o_y, o_rgb, o_de, o_hsync, o_vsync, o_frame_start
    );

endinterface

// File: rtl/lcd_axis_counter.sv
// One raster axis: wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK
// phase FSM. Used for pixels within a line and for lines within a frame.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_inc,
    output logic [POS_W-1:0] o_pos_nxt,
    output phase_e           o_phase,
    output phase_e           o_phase_nxt,
    output logic             o_wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] B_FRONT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] B_SYNC  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] B_BACK  = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic             step;

    always_comb begin
        step  = i_en & i_inc;
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Phase follows the post-step count so the next-state view is exact on the tick.
    always_comb begin
        phase_d = phase_q;
        if (step) begin
            case (phase_q)
                PH_ACTIVE: if (cnt_d == B_FRONT) phase_d = PH_FRONT;
                PH_FRONT:  if (cnt_d == B_SYNC)  phase_d = PH_SYNC;
                PH_SYNC:   if (cnt_d == B_BACK)  phase_d = PH_BACK;
                PH_BACK:   if (cnt_d == '0)      phase_d = PH_ACTIVE;
                default:                         phase_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= LAST;
            phase_q <= PH_BACK;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        o_pos_nxt   = cnt_d[POS_W-1:0];
        o_phase     = phase_q;
        o_phase_nxt = phase_d;
        o_wrap      = (cnt_q == LAST);
    end

endmodule

// File: rtl/lcd_scan_gen.sv
// Pixel-clock divider and raster scan master for the RGB LCD: presents x/y to
// the renderers and drives the returned colour to the panel one period later.
module lcd_scan_gen
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lcd_scan_gen_if.master bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               lcd_clk_q, lcd_clk_d;
    logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;

    logic               tick;
    logic               active_cur, active_nxt;
    logic [POS_W-1:0]   h_pos_nxt, v_pos_nxt;
    phase_e             h_phase, h_phase_nxt, v_phase, v_phase_nxt;
    logic               h_wrap, v_wrap;

    assign tick = (div_q == DIV_LAST);

    lcd_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk         (i_clk),
        .rst         (i_rst),
        .i_en        (tick),
        .i_inc       (1'b1),
        .o_pos_nxt   (h_pos_nxt),
        .o_phase     (h_phase),
        .o_phase_nxt (h_phase_nxt),
        .o_wrap      (h_wrap)
    );

    lcd_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk         (i_clk),
        .rst         (i_rst),
        .i_en        (tick),
        .i_inc       (h_wrap),
        .o_pos_nxt   (v_pos_nxt),
        .o_phase     (v_phase),
        .o_phase_nxt (v_phase_nxt),
        .o_wrap      (v_wrap)
    );

    always_comb begin
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        lcd_clk_d     = (div_d < DIV_HALF);
        active_cur    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        active_nxt    = (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
        x_d           = x_q;
        y_d           = y_q;
        rgb_d         = rgb_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = tick & h_wrap & v_wrap;
        // The tick is also the last cycle of the period: present the next
        // coordinate and ship the colour of the one just finished.
        if (tick) begin
            x_d     = active_nxt ? h_pos_nxt : '0;
            y_d     = active_nxt ? v_pos_nxt : '0;
            de_d    = active_cur;
            rgb_d   = active_cur ? bus.i_color : '0;
            hsync_d = (h_phase != PH_SYNC);
            vsync_d = (v_phase != PH_SYNC);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q         <= DIV_LAST;
            lcd_clk_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            lcd_clk_q     <= lcd_clk_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.o_lcd_clk     = lcd_clk_q;
    assign bus.o_x           = x_q;
    assign bus.o_y           = y_q;
    assign bus.o_rgb         = rgb_q;
    assign bus.o_de          = de_q;
    assign bus.o_hsync       = hsync_q;
    assign bus.o_vsync       = vsync_q;
    assign bus.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_scan_gen.sv
// Directed bench for lcd_scan_gen on a shrunken 28x12 raster so whole frames
// fit in a short run; renderer modelled as a 5-cycle colour pipeline.
module tb_lcd_scan_gen;

    localparam int CLK_DIV  = 8;
    localparam int H_ACTIVE = 20;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_white = 1'b0;
    logic [23:0] pipe [5];

    int checks = 0;
    int errors = 0;

    lcd_scan_gen_if bus ();

    lcd_scan_gen #(
        .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Renderer stand-in: colour derived from the coordinate, 5 cycles late.
    always @(posedge clk) begin
        pipe[0] <= {bus.o_x[7:0], bus.o_y[7:0], 8'hA5};
        for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.i_color = force_white ? 24'hFFFFFF : pipe[4];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y, input int budget, input string tag);
        int n = 0;
        while (!(bus.o_x == 9'(x) && bus.o_y == 9'(y)) && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_lcd_clk"}, 32'(bus.o_lcd_clk), 32'd0);
        check({pfx, "_x"}, 32'(bus.o_x), 32'd0);
        check({pfx, "_y"}, 32'(bus.o_y), 32'd0);
        check({pfx, "_rgb"}, 32'(bus.o_rgb), 32'd0);
        check({pfx, "_de"}, 32'(bus.o_de), 32'd0);
        check({pfx, "_hsync"}, 32'(bus.o_hsync), 32'd1);
        check({pfx, "_vsync"}, 32'(bus.o_vsync), 32'd1);
        check({pfx, "_frame_start"}, 32'(bus.o_frame_start), 32'd0);
    endtask

    initial begin
        int n;
        int t;
        int t_de_fall, t_hs_fall, t_hs_rise, t_vs_fall, t_vs_rise, hs_falls;
        logic prev_de, prev_hs, prev_vs;

        // Reset state
        rst = 1'b1;
        step(2);
        check_reset_outputs("rst");

        // First edge after release is a pixel tick presenting (0,0)
        rst = 1'b0;
        step(1);
        check("first_lcd_clk", 32'(bus.o_lcd_clk), 32'd1);
        check("first_x", 32'(bus.o_x), 32'd0);
        check("first_y", 32'(bus.o_y), 32'd0);
        check("first_frame_start", 32'(bus.o_frame_start), 32'd1);

        // Pixel clock: 8-cycle period, 4 high
        for (int i = 0; i < 16; i++) begin
            check("lcd_clk_wave", 32'(bus.o_lcd_clk), 32'((i % 8) < 4));
            if (i == 1) check("frame_start_single", 32'(bus.o_frame_start), 32'd0);
            step(1);
        end

        // Frame: length, vsync window, one hsync per line
        n = 0;
        while (!bus.o_frame_start && n < 3000) begin step(1); n++; end
        check("wait_frame_start", 32'(n < 3000), 32'd1);
        t = 0; t_vs_fall = -1; t_vs_rise = -1; hs_falls = 0;
        prev_hs = bus.o_hsync; prev_vs = bus.o_vsync;
        do begin
            step(1);
            t++;
            if (prev_hs && !bus.o_hsync) hs_falls++;
            if (prev_vs && !bus.o_vsync) t_vs_fall = t;
            if (!prev_vs && bus.o_vsync) t_vs_rise = t;
            prev_hs = bus.o_hsync;
            prev_vs = bus.o_vsync;
        end while (!bus.o_frame_start && t < 3000);
        check("frame_len_cycles", 32'(t), 32'd2688);
        check("lines_per_frame", 32'(hs_falls), 32'd12);
        check("vsync_fall", 32'(t_vs_fall), 32'd1800);
        check("vsync_rise", 32'(t_vs_rise), 32'd2472);

        // Colour latency: pixel (10,3) reaches the pins one period later
        wait_xy(10, 3, 3000, "wait_10_3");
        step(8);
        check("rgb_10_3", 32'(bus.o_rgb), 32'h000A03A5);
        check("de_10_3", 32'(bus.o_de), 32'd1);
        check("x_after_10", 32'(bus.o_x), 32'd11);
        check("y_after_10", 32'(bus.o_y), 32'd3);

        // Line: DE width, hsync placement, ticks per line
        n = 0;
        prev_de = bus.o_de;
        do begin
            prev_de = bus.o_de;
            step(1);
            n++;
        end while (!(!prev_de && bus.o_de) && n < 500);
        check("wait_de_rise", 32'(n < 500), 32'd1);
        t = 0; t_de_fall = -1; t_hs_fall = -1; t_hs_rise = -1;
        prev_de = bus.o_de; prev_hs = bus.o_hsync;
        do begin
            step(1);
            t++;
            if (prev_de && !bus.o_de) t_de_fall = t;
            if (prev_hs && !bus.o_hsync) t_hs_fall = t;
            if (!prev_hs && bus.o_hsync) t_hs_rise = t;
            if (!prev_de && bus.o_de) break;
            prev_de = bus.o_de;
            prev_hs = bus.o_hsync;
        end while (t < 500);
        check("de_high_cycles", 32'(t_de_fall), 32'd160);
        check("hsync_fall_after_de", 32'(t_hs_fall), 32'd176);
        check("hsync_rise_after_de", 32'(t_hs_rise), 32'd208);
        check("line_len_cycles", 32'(t), 32'd224);

        // Blanking masks coordinates and colour even with a white renderer
        force_white = 1'b1;
        wait_xy(19, 2, 3000, "wait_19_2");
        step(8);
        check("blank_x", 32'(bus.o_x), 32'd0);
        check("blank_y", 32'(bus.o_y), 32'd0);
        check("last_active_rgb", 32'(bus.o_rgb), 32'hFFFFFF);
        check("last_active_de", 32'(bus.o_de), 32'd1);
        step(8);
        check("blank_rgb", 32'(bus.o_rgb), 32'd0);
        check("blank_de", 32'(bus.o_de), 32'd0);
        force_white = 1'b0;

        // Asynchronous reset mid-line, then restart at (0,0)
        wait_xy(12, 4, 3000, "wait_12_4");
        step(3);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step(3);
        check_reset_outputs("held_rst");
        rst = 1'b0;
        step(1);
        check("restart_lcd_clk", 32'(bus.o_lcd_clk), 32'd1);
        check("restart_x", 32'(bus.o_x), 32'd0);
        check("restart_y", 32'(bus.o_y), 32'd0);
        check("restart_frame_start", 32'(bus.o_frame_start), 32'd1);
        step(8);
        check("restart_rgb", 32'(bus.o_rgb), 32'h0000A5);
        check("restart_de", 32'(bus.o_de), 32'd1);
        check("restart_x1", 32'(bus.o_x), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
